// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack channel plus the decode-facing queue head.
// master = fetch unit, slave = memory/decode side.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic              if_valid;
  logic [DATA_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_pc;
  logic              id_ready;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc,
    input  imem_ack, imem_rdata, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc,
    output imem_ack, imem_rdata, id_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem read at a time, results buffered in a small
// circular queue toward decode; pc_stall holds the PC until a fetch is accepted.
module fetch_unit #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned QDEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              flush,
  output logic              pc_stall,
  fetch_unit_if.master      bus
);
  localparam int unsigned PtrW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CntW = $clog2(QDEPTH + 1);

  typedef enum logic [1:0] {StIdle, StWait, StDiscard} state_e;

  state_e            state_q;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] q_instr [QDEPTH];
  logic [ADDR_W-1:0] q_pc    [QDEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;

  logic accept, push, pop, not_empty;

  always_comb begin
    not_empty = (count_q != '0);
    accept    = (state_q == StWait) && bus.imem_ack && !flush;
    push      = accept;
    pop       = not_empty && bus.id_ready;
    pc_stall  = ~(accept | flush);

    bus.imem_req  = req_q;
    bus.imem_addr = addr_q;
    bus.if_valid  = not_empty;
    bus.if_instr  = not_empty ? q_instr[rd_ptr_q] : '0;
    bus.if_pc     = not_empty ? q_pc[rd_ptr_q] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      req_q    <= 1'b0;
      addr_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(QDEPTH); i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else begin
      // Request side: the handshake always completes, even across a flush.
      unique case (state_q)
        StIdle: begin
          if (!flush && (count_q < CntW'(QDEPTH))) begin
            addr_q  <= pc_addr;
            req_q   <= 1'b1;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (bus.imem_ack) begin
            req_q   <= 1'b0;
            state_q <= StIdle;
          end else if (flush) begin
            state_q <= StDiscard;
          end
        end
        StDiscard: begin
          if (bus.imem_ack) begin
            req_q   <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= StIdle;
        end
      endcase

      // Queue side: flush wins over push and pop.
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) begin
          q_instr[wr_ptr_q] <= bus.imem_rdata;
          q_pc[wr_ptr_q]    <= addr_q;
          wr_ptr_q          <= wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PtrW'(1);
        end
        if (push && !pop) begin
          count_q <= count_q + CntW'(1);
        end else if (pop && !push) begin
          count_q <= count_q - CntW'(1);
        end
      end
    end
  end
endmodule
